// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with memory-wait timeout and sticky trap
// Optional LUI/AUIPC decode is enabled by defining CTRL_UPPER_IMM_EN.
module multicycle_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       branch_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] imm_src_o,
  output logic [1:0] alu_op_o,
  output logic       retire_o,
  output logic [1:0] trap_cause_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`ifdef CTRL_UPPER_IMM_EN
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`endif

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
`ifdef CTRL_UPPER_IMM_EN
  localparam logic [2:0] IMM_U = 3'b100;
`endif

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR,
`ifdef CTRL_UPPER_IMM_EN
    S_LUI,
`endif
    S_TRAP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       trap_cause, cause_set;
  logic             timeout_hit, mem_wait;
  logic             mem_req, mem_write, ir_write, pc_write, branch, reg_write, retire;

  // Hit on the last permitted wait cycle; a ready in that same cycle still takes priority.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(wait_cnt) == TIMEOUT_CYCLES - 1);
  assign mem_wait    = mem_req && !mem_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      trap_cause <= 2'b00;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (mem_wait)
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (cause_set != 2'b00)
        trap_cause <= cause_set;
    end
  end

  always_comb begin
    state_next   = state;
    cause_set    = 2'b00;
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    adr_src_o    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    branch       = 1'b0;
    reg_write    = 1'b0;
    retire       = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    imm_src_o    = 3'b000;
    alu_op_o     = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req      = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        if (mem_ready_i) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_set  = 2'b10;
        end
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        imm_src_o   = IMM_B;
        if (op_i == OP_JAL) imm_src_o = IMM_J;
`ifdef CTRL_UPPER_IMM_EN
        if (op_i == OP_AUIPC) imm_src_o = IMM_U;
`endif
        case (op_i)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
`ifdef CTRL_UPPER_IMM_EN
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_ALUWB;
`endif
          default: begin
            state_next = S_TRAP;
            cause_set  = 2'b01;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        imm_src_o   = op_i[5] ? IMM_S : IMM_I;
        state_next  = op_i[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req   = 1'b1;
        adr_src_o = 1'b1;
        if (mem_ready_i) begin
          state_next = S_MEMWB;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_set  = 2'b10;
        end
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write    = 1'b1;
        retire       = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src_o = 1'b1;
        if (mem_ready_i) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_set  = 2'b10;
        end
      end
      S_EXECR: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b10;
        state_next  = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        imm_src_o   = IMM_I;
        alu_op_o    = 2'b10;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b01;
        branch      = 1'b1;
        retire      = 1'b1;
        state_next  = S_FETCH;
      end
      S_JALR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        imm_src_o   = IMM_I;
        state_next  = S_JAL;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write    = 1'b1;
        state_next  = S_ALUWB;
      end
`ifdef CTRL_UPPER_IMM_EN
      S_LUI: begin
        alu_src_a_o = 2'b11;
        alu_src_b_o = 2'b01;
        imm_src_o   = IMM_U;
        state_next  = S_ALUWB;
      end
`endif
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  // Enables drop combinationally with reset so nothing commits or stays requested.
  assign mem_req_o    = mem_req & ~rst_i;
  assign mem_write_o  = mem_write & ~rst_i;
  assign ir_write_o   = ir_write & ~rst_i;
  assign pc_write_o   = pc_write & ~rst_i;
  assign branch_o     = branch & ~rst_i;
  assign reg_write_o  = reg_write & ~rst_i;
  assign retire_o     = retire & ~rst_i;
  assign trap_cause_o = trap_cause;

endmodule
